fetch_ctl: RTL and testbench
============================

Name: fetch_ctl

Overview:
- Instruction-fetch controller for the RV32I pipeline; it consumes the execute-stage redirect (pc_sel plus ALU target) that execute control produces.
- Owns the architectural PC and issues single-outstanding requests on the instruction-memory request/response interface.
- Presents fetched instructions to decode with a valid/stall handshake and a one-entry skid buffer.
- On redirect it squashes wrong-path fetches and pulses flush to the downstream stages.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
XLEN, 32, address/data width (only 32 supported)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
pc_sel  input  1  redirect request from execute control, sampled each clock
alu_out  input  XLEN  branch/jump target, valid when pc_sel=1
stall  input  1  decode cannot accept an instruction this cycle
imem_req  output  1  fetch request
imem_addr  output  XLEN  fetch address, word aligned
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid; arrives at least 1 cycle after grant
imem_rdata  input  XLEN  instruction word
instruction  output  XLEN  instruction presented to decode
pc  output  XLEN  address of instruction
pc_plus4  output  XLEN  pc+4, for JAL/JALR link
if_valid  output  1  instruction/pc valid
flush  output  1  one-cycle pulse: kill decode and execute contents
misalign  output  1  one-cycle pulse: redirect target had bits[1:0]!=0

Behaviour:
- Reset values: state=FETCH; fetch_pc=RESET_PC; instruction=0, pc=0, if_valid=0, flush=0, misalign=0, skid empty. imem_req=1 in the first cycle after rst deasserts.
- Reset is asynchronous: outputs take their reset values immediately on rst assertion. All other updates occur on the clk rising edge.
- imem_addr = fetch_pc. It stays stable while imem_req=1 and imem_gnt=0, except on a redirect.
- Handoff: decode consumes the instruction when if_valid=1 and stall=0. The output register may load when if_valid=0 or stall=0.
- States:
  - FETCH: imem_req=1. On imem_gnt, go to WAIT. An imem_rvalid seen in FETCH is ignored.
  - WAIT: imem_req=0. On imem_rvalid:
    - If the output register may load: load instruction=imem_rdata, pc=fetch_pc, if_valid=1; fetch_pc += 4; go to FETCH.
    - Otherwise: write the skid buffer; go to HOLD.
    - If the output is consumed this cycle and no new data arrives, if_valid goes to 0.
  - HOLD: imem_req=0. When stall=0, move skid to output; fetch_pc += 4; go to FETCH.
  - DROP: imem_req=0. Wait for imem_rvalid, discard the data, go to FETCH.
- Latency: granted in cycle N and rvalid in N+1 → if_valid in N+2. Back-to-back throughput is one instruction per 2 cycles; this is accepted.
- Redirect (pc_sel=1) has priority over stall and every other event in the same cycle:
  - fetch_pc <= {alu_out[31:2],2'b00}; if_valid <= 0; skid cleared; flush <= 1 for exactly one cycle.
  - misalign <= 1 for one cycle if alu_out[1:0]!=0.
- Next state on redirect:
  - FETCH with gnt=1: go to DROP (that request is in flight).
  - FETCH with gnt=0: stay in FETCH; the address changes to the target next cycle.
  - WAIT with rvalid=1: data discarded; go to FETCH.
  - WAIT with rvalid=0: go to DROP.
  - HOLD: go to FETCH.
  - DROP: stay in DROP.
- A redirect in consecutive cycles: the last target wins; flush is high in each following cycle.
- fetch_pc increment wraps modulo 2^32 (32'hFFFF_FFFC+4=0).
- pc_plus4 = pc+4, also wrapping.
- instruction and pc hold their values while if_valid=1 and stall=1.
- At most one request outstanding at any time; imem_req is never asserted in WAIT, HOLD or DROP.

Test Plan:
1. Reset, then gnt=1 always and rvalid one cycle after grant with rdata=0x00000013+pc, stall=0 → if_valid instructions at pc 0x0, 0x4, 0x8 carrying 0x13, 0x17, 0x1B; pc_plus4 = 0x4, 0x8, 0xC.
2. stall=1 held for 3 cycles while the response for 0x4 arrives → state HOLD, outputs stay at pc 0x0; after release, pc 0x4 then 0x8; no loss or duplication.
3. pc_sel=1 with alu_out=0x100 while in WAIT without rvalid; rvalid arrives 2 cycles later with 0xDEADBEEF → flush high one cycle, if_valid=0, 0xDEADBEEF never presented; the next request has imem_addr=0x100 and the next instruction has pc=0x100.
4. pc_sel=1 with alu_out=0x103 → misalign one-cycle pulse; imem_addr=0x100.
5. pc_sel=1 (alu_out=0x200) in the same cycle as rvalid, with stall=1 → data dropped, state FETCH, imem_addr=0x200, if_valid=0.
6. rst asserted mid-WAIT → if_valid=0 and flush=0 with no clock edge required; after release imem_addr=RESET_PC; a stray rvalid in FETCH is ignored and no instruction is presented.

Source files
------------

// File: rtl/fetch_ctl_if.sv
// Instruction-memory request/response bus: single-outstanding request with grant,
// response delivered later on rvalid.
interface fetch_ctl_if #(
  parameter int unsigned XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fetch_ctl.sv
// RV32I fetch controller: owns the PC, issues one imem request at a time and hands
// instructions to decode through a valid/stall register backed by a one-entry skid.
module fetch_ctl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_sel,
  input  logic [XLEN-1:0]   alu_out,
  input  logic              stall,
  fetch_ctl_if.master       imem,
  output logic [XLEN-1:0]   instruction,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              if_valid,
  output logic              flush,
  output logic              misalign
);

  typedef enum logic [1:0] {StFetch, StWait, StHold, StDrop} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] skid_q, skid_d;
  logic            valid_q, valid_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;
  logic            load_ok;

  assign load_ok = !valid_q || !stall;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    valid_d    = valid_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;

    if (valid_q && !stall) begin
      valid_d = 1'b0;
    end

    if (pc_sel) begin
      // Redirect wins over everything; an in-flight request must still be drained in StDrop.
      fetch_pc_d = {alu_out[XLEN-1:2], 2'b00};
      valid_d    = 1'b0;
      flush_d    = 1'b1;
      misalign_d = |alu_out[1:0];
      unique case (state_q)
        StFetch: state_d = imem.gnt ? StDrop : StFetch;
        StWait:  state_d = imem.rvalid ? StFetch : StDrop;
        StHold:  state_d = StFetch;
        StDrop:  state_d = StDrop;
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem.gnt) begin
            state_d = StWait;
          end
        end
        StWait: begin
          if (imem.rvalid) begin
            if (load_ok) begin
              instr_d    = imem.rdata;
              pc_d       = fetch_pc_q;
              valid_d    = 1'b1;
              fetch_pc_d = fetch_pc_q + XLEN'(4);
              state_d    = StFetch;
            end else begin
              skid_d  = imem.rdata;
              state_d = StHold;
            end
          end
        end
        StHold: begin
          // fetch_pc is only advanced once the skid drains, so it is the skid entry's PC.
          if (!stall) begin
            instr_d    = skid_q;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            state_d    = StFetch;
          end
        end
        StDrop: begin
          if (imem.rvalid) begin
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= '0;
      skid_q     <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      skid_q     <= skid_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem.req    = (state_q == StFetch);
  assign imem.addr   = fetch_pc_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign if_valid    = valid_q;
  assign flush       = flush_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed bench for fetch_ctl: drives the imem bus cycle by cycle and checks
// handoff, stall/skid, redirect, misalign, wrap and async reset against hand-derived values.
module tb_fetch_ctl;
  logic        clk = 1'b0;
  logic        rst;
  logic        pc_sel;
  logic [31:0] alu_out;
  logic        stall;
  logic [31:0] instruction, pc, pc_plus4;
  logic        if_valid, flush, misalign;
  int          errors = 0;
  int          checks = 0;

  fetch_ctl_if #(.XLEN(32)) imem ();

  fetch_ctl #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .alu_out     (alu_out),
    .stall       (stall),
    .imem        (imem),
    .instruction (instruction),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .if_valid    (if_valid),
    .flush       (flush),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Grant in one cycle, respond in the next.
  task automatic fetch_one(input logic [31:0] data);
    imem.gnt = 1'b1; imem.rvalid = 1'b0;
    cyc();
    imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = data;
    cyc();
    imem.rvalid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] p,
                         input logic [31:0] ins);
    chk({tag, " valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, " pc"}, pc, p);
    chk({tag, " instr"}, instruction, ins);
    chk({tag, " pc4"}, pc_plus4, p + 32'd4);
  endtask

  initial begin
    rst = 1'b1; pc_sel = 1'b0; alu_out = '0; stall = 1'b0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
    cyc(); cyc();
    chk("rst valid", {31'd0, if_valid}, 32'd0);
    chk("rst flush", {31'd0, flush}, 32'd0);
    chk("rst misalign", {31'd0, misalign}, 32'd0);
    chk("rst instr", instruction, 32'd0);
    chk("rst pc", pc, 32'd0);
    rst = 1'b0;
    cyc();
    chk("post rst req", {31'd0, imem.req}, 32'd1);
    chk("post rst addr", imem.addr, 32'h0);

    // 1: streaming fetch, latency grant N -> valid N+2
    imem.gnt = 1'b1;
    cyc();
    chk("wait req", {31'd0, imem.req}, 32'd0);
    chk("wait valid", {31'd0, if_valid}, 32'd0);
    imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h13;
    cyc();
    imem.rvalid = 1'b0;
    chk_out("t1 i0", 1'b1, 32'h0, 32'h13);
    chk("t1 addr", imem.addr, 32'h4);
    imem.gnt = 1'b1;
    cyc();
    chk("t1 consumed", {31'd0, if_valid}, 32'd0);
    imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h17;
    cyc();
    imem.rvalid = 1'b0;
    chk_out("t1 i1", 1'b1, 32'h4, 32'h17);
    fetch_one(32'h1B);
    chk_out("t1 i2", 1'b1, 32'h8, 32'h1B);

    // 2: stall while next response arrives -> skid/HOLD
    stall = 1'b1;
    imem.gnt = 1'b1;
    cyc();
    imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h1F;
    cyc();
    imem.rvalid = 1'b0;
    chk_out("t2 hold a", 1'b1, 32'h8, 32'h1B);
    chk("t2 hold req", {31'd0, imem.req}, 32'd0);
    cyc();
    chk_out("t2 hold b", 1'b1, 32'h8, 32'h1B);
    chk("t2 hold req b", {31'd0, imem.req}, 32'd0);
    stall = 1'b0;
    cyc();
    chk_out("t2 skid out", 1'b1, 32'hC, 32'h1F);
    chk("t2 addr", imem.addr, 32'h10);
    chk("t2 req", {31'd0, imem.req}, 32'd1);
    fetch_one(32'h23);
    chk_out("t2 next", 1'b1, 32'h10, 32'h23);

    // 3: redirect in WAIT without rvalid -> DROP, late data discarded
    imem.gnt = 1'b1;
    cyc();
    imem.gnt = 1'b0; pc_sel = 1'b1; alu_out = 32'h100;
    cyc();
    pc_sel = 1'b0;
    chk("t3 flush", {31'd0, flush}, 32'd1);
    chk("t3 misalign", {31'd0, misalign}, 32'd0);
    chk("t3 valid", {31'd0, if_valid}, 32'd0);
    chk("t3 drop req", {31'd0, imem.req}, 32'd0);
    cyc();
    chk("t3 flush pulse", {31'd0, flush}, 32'd0);
    imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF;
    cyc();
    imem.rvalid = 1'b0;
    chk("t3 dropped", {31'd0, if_valid}, 32'd0);
    chk("t3 req", {31'd0, imem.req}, 32'd1);
    chk("t3 addr", imem.addr, 32'h100);
    fetch_one(32'h113);
    chk_out("t3 target", 1'b1, 32'h100, 32'h113);

    // 4: misaligned target, redirect in FETCH without grant
    pc_sel = 1'b1; alu_out = 32'h103;
    cyc();
    pc_sel = 1'b0;
    chk("t4 misalign", {31'd0, misalign}, 32'd1);
    chk("t4 flush", {31'd0, flush}, 32'd1);
    chk("t4 addr", imem.addr, 32'h100);
    chk("t4 valid", {31'd0, if_valid}, 32'd0);
    cyc();
    chk("t4 misalign pulse", {31'd0, misalign}, 32'd0);
    chk("t4 req", {31'd0, imem.req}, 32'd1);

    // 5: redirect with rvalid and stall in the same cycle
    imem.gnt = 1'b1;
    cyc();
    imem.gnt = 1'b0; stall = 1'b1; pc_sel = 1'b1; alu_out = 32'h200;
    imem.rvalid = 1'b1; imem.rdata = 32'h55;
    cyc();
    pc_sel = 1'b0; imem.rvalid = 1'b0; stall = 1'b0;
    chk("t5 req", {31'd0, imem.req}, 32'd1);
    chk("t5 addr", imem.addr, 32'h200);
    chk("t5 valid", {31'd0, if_valid}, 32'd0);

    // back-to-back redirects, first with grant in FETCH -> DROP; last target wins
    pc_sel = 1'b1; alu_out = 32'h300; imem.gnt = 1'b1;
    cyc();
    imem.gnt = 1'b0; alu_out = 32'h400;
    chk("b2b flush a", {31'd0, flush}, 32'd1);
    chk("b2b drop req", {31'd0, imem.req}, 32'd0);
    cyc();
    pc_sel = 1'b0;
    chk("b2b flush b", {31'd0, flush}, 32'd1);
    imem.rvalid = 1'b1; imem.rdata = 32'h66;
    cyc();
    imem.rvalid = 1'b0;
    chk("b2b addr", imem.addr, 32'h400);
    chk("b2b valid", {31'd0, if_valid}, 32'd0);
    chk("b2b flush end", {31'd0, flush}, 32'd0);

    // wrap at top of address space
    pc_sel = 1'b1; alu_out = 32'hFFFF_FFFC;
    cyc();
    pc_sel = 1'b0;
    fetch_one(32'hAA);
    chk_out("wrap", 1'b1, 32'hFFFF_FFFC, 32'hAA);
    chk("wrap pc4", pc_plus4, 32'h0);
    chk("wrap addr", imem.addr, 32'h0);

    // 6: async reset mid-WAIT with a held valid instruction
    stall = 1'b1; imem.gnt = 1'b1;
    cyc();
    imem.gnt = 1'b0;
    chk("t6 pre valid", {31'd0, if_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6 async valid", {31'd0, if_valid}, 32'd0);
    chk("t6 async flush", {31'd0, flush}, 32'd0);
    chk("t6 async pc", pc, 32'd0);
    chk("t6 async addr", imem.addr, 32'h0);
    stall = 1'b0;
    cyc();
    rst = 1'b0;
    imem.rvalid = 1'b1; imem.rdata = 32'h77;
    cyc();
    imem.rvalid = 1'b0;
    chk("t6 stray valid", {31'd0, if_valid}, 32'd0);
    chk("t6 stray req", {31'd0, imem.req}, 32'd1);
    chk("t6 stray addr", imem.addr, 32'h0);
    fetch_one(32'h13);
    chk_out("t6 refetch", 1'b1, 32'h0, 32'h13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
